// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: requests one instruction word per pc_addr, decodes it into registered
// datapath controls, and holds them until the execute stage accepts. All state moves on negedge.
module instr_fetch_decode #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pc_addr,
  output logic [7:0]  imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        exec_ready,
  output logic        pc_inc,
  output logic        instr_valid,
  output logic        reg_write,
  output logic        imm_sel,
  output logic        neg_sel,
  output logic        illegal,
  output logic [2:0]  alu_op,
  output logic [2:0]  dest_reg,
  output logic [2:0]  src1_reg,
  output logic [2:0]  src2_reg,
  output logic [7:0]  imm,
  output logic        fetch_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StIssue, StErr} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic       dec_illegal;
  logic       dec_reg_write;
  logic       dec_imm_sel;
  logic       dec_neg_sel;
  logic [2:0] dec_alu_op;

  // Only the low three bits of the dest/src1 bytes address the register file.
  logic unused_rdata;
  assign unused_rdata = ^{imem_rdata[23:19], imem_rdata[15:11]};

  always_comb begin
    dec_illegal   = 1'b0;
    dec_reg_write = 1'b1;
    dec_imm_sel   = 1'b0;
    dec_neg_sel   = 1'b0;
    dec_alu_op    = 3'b000;
    case (imem_rdata[31:24])
      8'h00: dec_imm_sel = 1'b1;
      8'h01: dec_alu_op  = 3'b000;
      8'h02: dec_alu_op  = 3'b001;
      8'h03: begin
        dec_alu_op  = 3'b001;
        dec_neg_sel = 1'b1;
      end
      8'h04: dec_alu_op  = 3'b010;
      8'h05: dec_alu_op  = 3'b011;
      default: begin
        dec_illegal   = 1'b1;
        dec_reg_write = 1'b0;
      end
    endcase
  end

  // Reset must also mask acceptance within the same cycle.
  assign pc_inc = reset && (state_q == StIssue) && exec_ready;

  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      imem_addr   <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      reg_write   <= 1'b0;
      imm_sel     <= 1'b0;
      neg_sel     <= 1'b0;
      illegal     <= 1'b0;
      alu_op      <= '0;
      dest_reg    <= '0;
      src1_reg    <= '0;
      src2_reg    <= '0;
      imm         <= '0;
      fetch_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q   <= StReq;
          imem_req  <= 1'b1;
          imem_addr <= pc_addr;
          cnt_q     <= '0;
        end
        StReq: begin
          // A response on the final allowed cycle still wins over the timeout.
          if (imem_ready) begin
            state_q     <= StIssue;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            reg_write   <= dec_reg_write;
            imm_sel     <= dec_imm_sel;
            neg_sel     <= dec_neg_sel;
            illegal     <= dec_illegal;
            alu_op      <= dec_alu_op;
            dest_reg    <= imem_rdata[18:16];
            src1_reg    <= imem_rdata[10:8];
            src2_reg    <= imem_rdata[2:0];
            imm         <= imem_rdata[7:0];
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q   <= StErr;
            cnt_q     <= cnt_q + 1'b1;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StIssue: begin
          if (exec_ready) begin
            state_q     <= StReq;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pc_addr;
            cnt_q       <= '0;
          end
        end
        StErr: begin
          state_q <= StErr;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
